// File: rtl/mem_access_unit.sv
// Load/store sequencer between a core request port and a single-port synchronous RAM.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 30
`endif

module mem_access_unit #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [1:0]                 req_size_i,
    input  logic                       req_unsigned_i,
    input  logic [31:0]                req_addr_i,
    input  logic [`API_DATA_WIDTH-1:0] req_wdata_i,
    output logic                       resp_valid_o,
    output logic [`API_DATA_WIDTH-1:0] resp_rdata_o,
    output logic                       resp_err_o,
    output logic                       mem_en_n_o,
    output logic [`API_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [`API_DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]                 mem_wr_mask_o,
    input  logic [`API_DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int unsigned DW = `API_DATA_WIDTH;
    localparam logic [2:0] LastCnt = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic                       we_q, unsigned_q, err_q;
    logic [1:0]                 size_q, offset_q;
    logic [`API_ADDR_WIDTH-1:0] addr_q;
    logic [DW-1:0]              wdata_q, rdata_q;
    logic [3:0]                 mask_q;

    logic          accept, misalign, req_err, last_wait;
    logic [3:0]    store_mask;
    logic [DW-1:0] store_data, load_data;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;

    assign accept    = (state_q == StIdle) && req_valid_i;
    assign last_wait = (state_q == StWait) && (cnt_q == LastCnt);
    assign req_err   = (req_size_i == 2'b11) || misalign;

    always_comb begin
        misalign = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                   ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`endif
    end

    // Mask and lane selection use only the offset bits meaningful for the size,
    // so misaligned low bits are ignored when not trapping.
    always_comb begin
        store_mask = 4'b0000;
        store_data = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                store_mask = 4'b0001 << req_addr_i[1:0];
                store_data = {(DW/8){req_wdata_i[7:0]}};
            end
            2'b01: begin
                store_mask = req_addr_i[1] ? 4'b1100 : 4'b0011;
                store_data = {(DW/16){req_wdata_i[15:0]}};
            end
            2'b10:   store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    end

    assign load_byte = 8'(mem_rdata_i >> {offset_q, 3'b000});
    assign load_half = 16'(mem_rdata_i >> {offset_q[1], 4'b0000});

    always_comb begin
        load_data = mem_rdata_i;
        case (size_q)
            2'b00: load_data = unsigned_q ? {{(DW-8){1'b0}}, load_byte}
                                          : {{(DW-8){load_byte[7]}}, load_byte};
            2'b01: load_data = unsigned_q ? {{(DW-16){1'b0}}, load_half}
                                          : {{(DW-16){load_half[15]}}, load_half};
            default: load_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_o  = 1'b0;
        mem_en_n_o   = 1'b1;
        resp_valid_o = 1'b0;
        resp_err_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = req_err ? StResp : StAccess;
            end
            StAccess: begin
                mem_en_n_o = 1'b0;
                state_d    = we_q ? StResp : StWait;
            end
            StWait: begin
                if (last_wait) begin
                    state_d = StResp;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= 2'b00;
            offset_q   <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mask_q     <= 4'b0000;
        end else begin
            if (accept) begin
                we_q       <= req_we_i;
                unsigned_q <= req_unsigned_i;
                err_q      <= req_err;
                size_q     <= req_size_i;
                offset_q   <= req_addr_i[1:0];
                addr_q     <= req_addr_i[`API_ADDR_WIDTH+1:2];
                wdata_q    <= store_data;
                mask_q     <= (req_we_i && !req_err) ? store_mask : 4'b0000;
                rdata_q    <= '0;
            end
            if (last_wait) rdata_q <= load_data;
            // Response data is only non-zero while the response is presented.
            if (state_q == StResp) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_wr_mask_o = mask_q;
    assign resp_rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic against a byte-level RAM model.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 30
`endif

module tb_mem_access_unit;
    localparam int unsigned LAT = 3;

    logic        clk;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_en_n;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [`API_ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]  mem_wr_mask;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram  [16];
    logic [31:0] gold [16];
    logic [31:0] pipe [LAT];

    mem_access_unit #(.RD_LATENCY(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_size_i    (req_size),
        .req_unsigned_i(req_unsigned),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .resp_valid_o  (resp_valid),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err),
        .mem_en_n_o    (mem_en_n),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_wr_mask_o (mem_wr_mask),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    // RAM: read data valid for exactly one cycle, LAT edges after the enable edge; noise otherwise.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= $urandom;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) ram[i] <= pat(i);
        end else if (!mem_en_n) begin
            if (mem_wr_mask == 4'b0000) begin
                pipe[0] <= ram[mem_addr[3:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_wr_mask[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end
    assign mem_rdata = pipe[LAT-1];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] word, input int nb,
                                             input logic uns, input int base);
        longint v;
        if (nb == 4) return word;
        v = longint'((word >> (8 * base)) & ((32'd1 << (8 * nb)) - 32'd1));
        if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic init_gold();
        for (int i = 0; i < 16; i++) gold[i] = pat(i);
    endtask

    task automatic randomize_inputs(input logic valid);
        req_valid    = valid;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          output logic [31:0] got);
        int          nb, base, ncyc, idx;
        bit          err;
        logic [1:0]  off;
        logic [3:0]  emask;
        logic [31:0] ewdata, erdata;
        off = addr[1:0];
        idx = int'(addr[5:2]);
        err = (size == 2'b11);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if ((size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00)) err = 1'b1;
`endif
        nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = (int'(off) / nb) * nb;
        emask  = 4'b0000;
        ewdata = 32'h0;
        for (int b = 0; b < 4; b++) begin
            ewdata[8*b +: 8] = wdata[8*(b % nb) +: 8];
            if (we && b >= base && b < base + nb) emask[b] = 1'b1;
        end
        erdata = 32'h0;
        if (!err && !we) erdata = ext_load(gold[idx], nb, uns, base);
        if (!err && we)
            for (int b = base; b < base + nb; b++) gold[idx][8*b +: 8] = wdata[8*(b-base) +: 8];
        ncyc = err ? 1 : (we ? 2 : 2 + LAT);

        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        got = 32'hx;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("mem_en_n", 32'(mem_en_n), (k == 1 && !err) ? 32'd0 : 32'd1);
            chk("resp_valid", 32'(resp_valid), (k == ncyc) ? 32'd1 : 32'd0);
            if (!err && k < ncyc) begin
                chk("mem_addr", 32'(mem_addr), 32'(addr[31:2]));
                chk("mem_mask", 32'(mem_wr_mask), 32'(emask));
                if (we) chk("mem_wdata", mem_wdata, ewdata);
            end
            if (k == ncyc) begin
                chk("resp_err", 32'(resp_err), err ? 32'd1 : 32'd0);
                chk("resp_rdata", resp_rdata, erdata);
                got = resp_rdata;
            end
            randomize_inputs(hold && k < ncyc);
        end
        @(negedge clk);
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("no_extra_resp", 32'(resp_valid), 32'd0);
        chk("en_after", 32'(mem_en_n), 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_en", 32'(mem_en_n), 32'd1);
        chk("rst_mask", 32'(mem_wr_mask), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic        we, uns;
        logic [1:0]  sz;
        bit          hold;

        reset_n = 1'b0;
        randomize_inputs(1'b0);
        init_gold();
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, got);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00A5, 1'b0, got);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, got);
        chk("signed_byte", got, 32'hFFFF_FFA5);
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001_7FFF, 1'b0, got);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, got);
        chk("half_unsigned", got, 32'h0000_8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, got);
        chk("half_signed", got, 32'hFFFF_8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, got);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("misaligned_half", got, 32'h0);
`else
        chk("misaligned_half", got, 32'h0000_7FFF);
`endif
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, got);
        chk("held_valid_word", got, 32'h8001_7FFF);
        do_req(1'b1, 2'b11, 1'b0, 32'h24, 32'h1234_5678, 1'b0, got);

        for (int n = 0; n < 120; n++) begin
            we   = 1'($urandom);
            sz   = 2'($urandom);
            uns  = 1'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            do_req(we, sz, uns, $urandom, $urandom, hold, got);
        end

        // Reset in the middle of a load's wait phase.
        chk("pre_rst_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wait_en", 32'(mem_en_n), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        init_gold();
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            chk("post_rst_resp", 32'(resp_valid), 32'd0);
            chk("post_rst_en", 32'(mem_en_n), 32'd1);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, got);
        chk("post_rst_load", got, pat(8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter RD_LATENCY, default 1, meaning edges from the RAM read-enable edge to the edge where mem_rdata_i is sampled; legal range 1..4.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  1  core request valid.
REQ-005 req_ready_o  output  1  unit can accept a request.
REQ-006 req_we_i  input  1  1 = store, 0 = load.
REQ-007 req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr_i  input  32  byte address.
REQ-010 req_wdata_i  input  `API_DATA_WIDTH  store data, right-aligned.
REQ-011 resp_valid_o  output  1  one-cycle completion pulse.
REQ-012 resp_rdata_o  output  `API_DATA_WIDTH  extended load data, 0 for stores and errors.
REQ-013 resp_err_o  output  1  request rejected, valid with resp_valid_o.
REQ-014 mem_en_n_o  output  1  RAM chip select, active low.
REQ-015 mem_addr_o  output  `API_ADDR_WIDTH  word address, equal to req_addr_i[`API_ADDR_WIDTH+1:2].
REQ-016 mem_wdata_o  output  `API_DATA_WIDTH  lane-replicated store data.
REQ-017 mem_wr_mask_o  output  4  byte write enables; all-zero means read.
REQ-018 mem_rdata_i  input  `API_DATA_WIDTH  RAM read word.

Function
REQ-019 FSM states IDLE, ACCESS, WAIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-020 Accept on edge with req_valid_i=1 in IDLE; all request fields registered; IDLE->ACCESS; req_* ignored until next IDLE.
REQ-021 ACCESS lasts exactly one cycle with mem_en_n_o=0; mem_en_n_o SHALL be 1 in every other state.
REQ-022 Store: ACCESS->RESP; resp_valid_o high in the cycle after the ACCESS edge (2 cycles after accept).
REQ-023 Load: ACCESS->WAIT; WAIT counts RD_LATENCY edges, samples mem_rdata_i on the last one, ->RESP; resp_valid_o high RD_LATENCY+1 cycles after the ACCESS edge.
REQ-024 RESP lasts one cycle, then ->IDLE; no response back-pressure; new request acceptable on the RESP->IDLE edge+1.
REQ-025 mem_addr_o, mem_wdata_o, mem_wr_mask_o SHALL be held stable from ACCESS through WAIT.
REQ-026 Loads SHALL drive mem_wr_mask_o=0000; stores never drive 0000.
REQ-027 Store mask: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111.
REQ-028 Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-029 Load data: word shifted right by 8*addr[1:0] (half: 16*addr[1]), then 8/16-bit field sign- or zero-extended per req_unsigned_i; word passed unchanged.
REQ-030 req_size_i=11 SHALL always produce error: no memory access, IDLE->RESP, resp_err_o=1, resp_rdata_o=0.

Reset
REQ-031 Asynchronous reset_n low SHALL force state IDLE, req_ready_o=1, mem_en_n_o=1, mem_wr_mask_o=0, mem_addr_o=0, mem_wdata_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, WAIT counter 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it immediately with no response pulse after release.

Configuration
REQ-033 Macro MEM_ACCESS_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 SHALL skip memory (IDLE->RESP), resp_err_o=1, resp_rdata_o=0, response 1 cycle after accept.
REQ-034 Macro undefined: misaligned offset bits SHALL be forced to zero (half ignores addr[0], word ignores addr[1:0]), access proceeds normally, resp_err_o=0.

Verification
REQ-035 Store word 0xDEADBEEF @0x10 -> one cycle mem_en_n_o=0, mem_addr_o=4, mask 1111; resp_valid_o 2 cycles after accept, err 0.
REQ-036 Store byte 0xA5 @0x13 then load byte signed @0x13 (RD_LATENCY=1) -> mask 1000, wdata 0xA5A5A5A5; load mask 0000, resp_rdata_o=0xFFFFFFA5 3 cycles after accept.
REQ-037 Load half unsigned @0x12 with RAM word 0x8001_7FFF -> resp_rdata_o=0x00008001; signed -> 0xFFFF8001.
REQ-038 Load half @0x11 -> with MEM_ACCESS_MISALIGN_TRAP_EN: no mem_en_n_o pulse, resp_err_o=1 1 cycle after accept; without: reads offset 0x10, err 0.
REQ-039 RD_LATENCY=3 load, req_valid_i held high throughout -> req_ready_o low 5 cycles, single resp_valid_o pulse, second request accepted only after IDLE.
REQ-040 reset_n pulsed low during WAIT -> mem_en_n_o=1, all outputs at reset values, no resp_valid_o after release; size=11 request -> resp_err_o=1, no memory access.
